mem_bus_arbiter: RTL

//  Shares one external memory bus between the IF stage (instruction reads) and the MEM stage (data loads/stores).

---
 rtl/mem_bus_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the IF and MEM pipeline stages onto one req/ack memory bus.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_data,
  output logic                  if_ready,
  input  logic                  d_re,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_byte_slct,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_byte_slct,
  output logic                  bus_re,
  output logic                  bus_we,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic                  bus_err,
  output logic                  stall_req,
  output logic [1:0]            state_dbg
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  // Handshake: each requester holds its level request until it sees its ready
  // pulse; the bus side holds bus_re/bus_we for the whole BUSY state and the
  // transfer completes on the first cycle bus_ack is high while a strobe is up.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state, state_next;
  logic          d_req;
  logic          any_req;
  logic          pick_d;
  logic          grant_d;
  logic          timed_out;
  logic [CW-1:0] cnt;
  logic          ack_hit;
  logic          timeout_hit;

  assign d_req       = d_re | d_we;
  assign any_req     = d_req | if_req;
  assign ack_hit     = (state == BUSY) && bus_ack;
  assign timeout_hit = (state == BUSY) && !bus_ack && (cnt == CNT_LAST);

`ifdef MEM_ARB_RR_EN
  // last_grant = 1 means IF won last; the reset value 0 lets IF win first.
  logic last_grant;

  always_comb begin
    pick_d = d_req && (!if_req || last_grant);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_grant <= !pick_d;
    end
  end
`else
  // Data wins: the older instruction in MEM must drain before IF moves on.
  always_comb begin
    pick_d = d_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (ack_hit || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    if_ready  = (state == RESP) && !grant_d;
    d_ready   = (state == RESP) && grant_d;
    bus_err   = (state == RESP) && timed_out;
    state_dbg = state;
    stall_req = (if_req && !if_ready) || (d_req && !d_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_byte_slct <= '0;
      bus_re        <= 1'b0;
      bus_we        <= 1'b0;
      if_data       <= '0;
      d_rdata       <= '0;
      grant_d       <= 1'b0;
      timed_out     <= 1'b0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_d   <= pick_d;
            timed_out <= 1'b0;
            cnt       <= '0;
            if (pick_d) begin
              bus_addr      <= d_addr;
              bus_wdata     <= d_wdata;
              bus_byte_slct <= d_byte_slct;
              bus_we        <= d_we;
              bus_re        <= !d_we;
            end else begin
              bus_addr      <= if_addr;
              bus_byte_slct <= 4'b1111;
              bus_we        <= 1'b0;
              bus_re        <= 1'b1;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (bus_ack) begin
            bus_re <= 1'b0;
            bus_we <= 1'b0;
            if (bus_re) begin
              if (grant_d) d_rdata <= bus_rdata;
              else         if_data <= bus_rdata;
            end
          end else if (cnt == CNT_LAST) begin
            bus_re    <= 1'b0;
            bus_we    <= 1'b0;
            timed_out <= 1'b1;
            if (grant_d) d_rdata <= '0;
            else         if_data <= '0;
          end
        end
        default: begin
          bus_re <= 1'b0;
          bus_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
